// File: rtl/ms_tick_debounce.sv
// 1 ms timebase (square wave + tick) and pushbutton debouncer with press one-shot.
// Optional BTN_ACTIVE_LOW_EN: treat a low pin level as pressed.
module ms_tick_debounce #(
    parameter int DIV         = 50000,
    parameter int DEBOUNCE_MS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic clk_1ms,
    output logic tick_1ms,
    output logic btn_level,
    output logic btn_press
);

    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clk_1ms_q, clk_1ms_d;
    logic                   tick_q, tick_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic [DEBOUNCE_MS-1:0] sh_q, sh_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   btn_in;
    logic                   wrap;
    logic                   strobe;

`ifdef BTN_ACTIVE_LOW_EN
    // Inverted ahead of the synchronizer, so reset zeros mean "pin high".
    assign btn_in = ~btn;
`else
    assign btn_in = btn;
`endif

    assign wrap   = (cnt_q == CW'(DIV - 1));
    assign strobe = (cnt_q == CW'(HALF - 1));

    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        clk_1ms_d = clk_1ms_q;
        tick_d    = wrap;
        sync1_d   = btn_in;
        sync2_d   = sync1_q;
        sh_d      = sh_q;
        level_d   = level_q;
        press_d   = press_q;
        if (wrap) begin
            clk_1ms_d = 1'b1;
        end
        if (strobe) begin
            clk_1ms_d = 1'b0;
            sh_d      = {sh_q[DEBOUNCE_MS-2:0], sync2_q};
            if (&sh_d) begin
                level_d = 1'b1;
            end else if (~|sh_d) begin
                level_d = 1'b0;
            end
            // Set on a rising level, cleared at the next falling edge.
            press_d = level_d & ~level_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            clk_1ms_q <= 1'b0;
            tick_q    <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sh_q      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_1ms_q <= clk_1ms_d;
            tick_q    <= tick_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sh_q      <= sh_d;
            level_q   <= level_d;
            press_q   <= press_d;
        end
    end

    assign clk_1ms   = clk_1ms_q;
    assign tick_1ms  = tick_q;
    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: tb/tb_ms_tick_debounce.sv
// Bench for ms_tick_debounce: vector table, corner sequences, random runs vs model.
// Stimulus is given as logical "pressed"; pin polarity follows BTN_ACTIVE_LOW_EN.
module tb_ms_tick_debounce;

    localparam int DIV  = 10;
    localparam int HALF = DIV / 2;
    localparam int DB   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn;
    logic clk_1ms, tick_1ms, btn_level, btn_press;

    ms_tick_debounce #(.DIV(DIV), .DEBOUNCE_MS(DB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .clk_1ms  (clk_1ms),
        .tick_1ms (tick_1ms),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int k;
    bit m_b1, m_b2;
    bit run_val;
    int run_len;
    bit m_level, m_press;

    int  pulses;
    int  press_len;
    int  caps;
    bit  in_pulse;
    bit  prev_press, prev_clk;

    typedef struct {
        bit val;
        int cycles;
        int exp_pulses;
        bit exp_level;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    task automatic set_pin(input bit p);
`ifdef BTN_ACTIVE_LOW_EN
        btn = ~p;
`else
        btn = p;
`endif
    endtask

    task automatic model_reset();
        k = 0;
        m_b1 = 0;
        m_b2 = 0;
        run_val = 0;
        run_len = DB;
        m_level = 0;
        m_press = 0;
        in_pulse = 0;
        prev_press = 0;
        prev_clk = 0;
    endtask

    // Level follows the value of any run of DB equal millisecond samples.
    task automatic model_edge(input bit p);
        bit s;
        bit nl;
        s = m_b2;
        m_b2 = m_b1;
        m_b1 = p;
        k++;
        if (k % DIV == HALF) begin
            if (s == run_val) run_len++;
            else begin
                run_val = s;
                run_len = 1;
            end
            nl = m_level;
            if (run_len >= DB) nl = run_val;
            m_press = nl & ~m_level;
            m_level = nl;
        end
    endtask

    task automatic step(input bit p);
        bit exp_clk, exp_tick;
        set_pin(p);
        @(posedge clk);
        model_edge(p);
        @(negedge clk);
        exp_clk  = (k >= DIV) && (k % DIV < HALF);
        exp_tick = (k >= DIV) && (k % DIV == 0);
        check("clk_1ms", clk_1ms, exp_clk);
        check("tick_1ms", tick_1ms, exp_tick);
        check("btn_level", btn_level, m_level);
        check("btn_press", btn_press, m_press);
        if (btn_press && !prev_press) begin
            pulses++;
            in_pulse = 1;
            press_len = 0;
            caps = 0;
        end
        if (in_pulse && btn_press) begin
            press_len++;
            if (clk_1ms && !prev_clk) caps++;
        end
        if (in_pulse && !btn_press) begin
            in_pulse = 0;
            check("press_width", press_len, DIV);
            check("press_captures", caps, 1);
        end
        prev_press = btn_press;
        prev_clk = clk_1ms;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_clk_1ms", clk_1ms, 0);
        check("rst_tick", tick_1ms, 0);
        check("rst_level", btn_level, 0);
        check("rst_press", btn_press, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0, n;
        bit v;
        tbl[0] = '{0, 30, 0, 0};
        tbl[1] = '{1, 50, 1, 1};
        tbl[2] = '{1, 100, 0, 1};
        tbl[3] = '{0, 50, 0, 0};
        tbl[4] = '{1, 20, 0, 0};
        tbl[5] = '{0, 30, 0, 0};
        tbl[6] = '{1, 45, 1, 1};
        tbl[7] = '{0, 60, 0, 0};

        pulses = 0;
        set_pin(0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("init_clk_1ms", clk_1ms, 0);
        check("init_tick", tick_1ms, 0);
        check("init_level", btn_level, 0);
        check("init_press", btn_press, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            p0 = pulses;
            repeat (tbl[i].cycles) step(tbl[i].val);
            check($sformatf("vec%0d_pulses", i), pulses - p0, tbl[i].exp_pulses);
            check($sformatf("vec%0d_level", i), btn_level, tbl[i].exp_level);
        end

        p0 = pulses;
        for (int i = 0; i < 14; i++) begin
            repeat (7) step(i % 2 == 0);
        end
        repeat (50) step(0);
        check("bounce_pulses", pulses - p0, 0);
        check("bounce_level", btn_level, 0);

        n = 0;
        while (!btn_press && n < 100) begin
            step(1);
            n++;
        end
        check("press_seen_before_reset", btn_press, 1);
        async_reset();
        n = 0;
        do begin
            step(0);
            n++;
        end while (!clk_1ms && n < 3 * DIV);
        check("first_rise_after_reset", n, DIV);

        for (int r = 0; r < 40; r++) begin
            v = $urandom_range(0, 1);
            repeat ($urandom_range(1, 60)) step(v);
        end
        repeat (60) step(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ms_tick_debounce.md
Name: ms_tick_debounce

Overview:
- Timebase-plus-pushbutton front end for the game logic.
- Divides the system clock into a 1 ms square wave (`clk_1ms`) and a 1 ms single-cycle enable (`tick_1ms`).
- Debounces one raw pushbutton, sampling once per millisecond.
- Produces a clean level and a one-shot press flag. The flag is wide enough to be captured exactly once by logic clocked on the rising edge of `clk_1ms`.

Parameters:
- DIV, 50000, system clocks per 1 ms period; must be even and >= 4.
- HALF, DIV/2, derived local: clocks in the high phase of `clk_1ms`.
- DEBOUNCE_MS, 8, consecutive equal 1 ms samples needed to change the debounced level; >= 2.

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  1  raw asynchronous pushbutton, active high.
- clk_1ms  output  1  registered 50% duty square wave, period DIV clocks.
- tick_1ms  output  1  one-clk pulse, once per DIV clocks.
- btn_level  output  1  debounced button level.
- btn_press  output  1  press one-shot, high for exactly one `clk_1ms` period.

Behaviour:
- Reset: while `rst_n`=0, all registers clear immediately.
  - Outputs: `clk_1ms`=0, `tick_1ms`=0, `btn_level`=0, `btn_press`=0.
  - Internal: cnt=0, synchronizer flops=0, sample shift register=all 0.
- Divider:
  - cnt counts 0..DIV-1 and wraps to 0; it advances every clk with no enable.
  - `clk_1ms` is set on the edge where cnt goes DIV-1 -> 0. It is cleared on the edge where cnt goes HALF-1 -> HALF.
  - First `clk_1ms` rise occurs DIV clocks after reset release.
- `tick_1ms`: registered. High for the single clk cycle immediately following each `clk_1ms` rising edge, otherwise 0.
- Synchronizer: `btn` passes through 2 flops on clk before any use.
- Sampling:
  - On each edge where `clk_1ms` falls (cnt HALF-1 -> HALF), the synchronized `btn` shifts into a DEBOUNCE_MS-bit register.
  - No other edge modifies it.
- Level update, on the same falling-edge strobe, evaluated on the post-shift contents:
  - All ones -> `btn_level`=1.
  - All zeros -> `btn_level`=0.
  - Mixed -> hold.
- Press:
  - On a falling-edge strobe where `btn_level` transitions 0 -> 1, `btn_press` is set.
  - On the next falling-edge strobe, `btn_press` is cleared unconditionally.
  - Result: `btn_press` is high for exactly DIV clocks, spanning exactly one `clk_1ms` rising edge.
- Stability: `btn_level` and `btn_press` change only at `clk_1ms` falling edges. They are therefore stable across every `clk_1ms` rising edge.
- Held button: one `btn_press` only. A new press requires `btn_level` to return to 0, which needs DEBOUNCE_MS zero samples.
- Bounce: a glitch shorter than DEBOUNCE_MS consecutive samples produces no level change and no press.
- Latency: from `btn` rising (held clean), `btn_level` rises at the DEBOUNCE_MS-th falling-edge strobe that sees synchronized `btn`=1. This is between (DEBOUNCE_MS-1)*DIV+2 and DEBOUNCE_MS*DIV+2 clocks.
- Reset mid-operation: everything returns to reset values. A press in progress is discarded and `btn_press` drops immediately.

Optional Feature:
- Macro BTN_ACTIVE_LOW_EN.
- Defined: `btn` is inverted before the synchronizer, so a 0 on the pin means pressed. The synchronizer and shift-register reset values become 1 on the pin side, i.e. still "not pressed" after inversion. `btn_level` and `btn_press` remain active high.
- Undefined: `btn` is active high as described above.

Test Plan:
- Divider (DIV=10): release reset, run 60 clks -> `clk_1ms` rises at clk 10, 20, 30… and falls at 15, 25…; `tick_1ms` is high exactly one cycle after each rise; period 10, duty 5/5.
- Clean press (DIV=10, DEBOUNCE_MS=4): hold `btn`=1 from clk 3 -> `btn_level` rises within 32–42 clks; `btn_press` is high for exactly 10 clks; exactly one `clk_1ms` rising edge samples it at 1.
- Bounce: toggle `btn` 1/0 every 7 clks for 100 clks, then settle at 0 -> `btn_level` and `btn_press` stay 0.
- Hold then release: hold `btn`=1 for 200 clks, release, press again after 60 clks -> exactly two `btn_press` pulses; `btn_level` returns to 0 about 40 clks after release.
- Async reset mid-press: assert `rst_n`=0 while `btn_press`=1 -> all outputs 0 immediately, without waiting for clk; after release, `clk_1ms` first rises 10 clks later.
- BTN_ACTIVE_LOW_EN defined: `btn` idles at 1 after reset -> no press; driving 0 for 50 clks -> one `btn_press` pulse.
